// File: rtl/rns_reconstruct.sv
// Converts a residue pair (mod 256, mod MOD_LO) to binary via mixed-radix
// reconstruction: x = r_hi + 256 * ((r_lo - r_hi) * 256^-1 mod MOD_LO).
module rns_reconstruct #(
  parameter int unsigned MOD_LO    = 129,
  parameter int unsigned INV_SHIFT = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] din,
  input  logic [3:0]  tag_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] dout,
  output logic [3:0]  tag_out,
  output logic        out_err
);

  localparam logic [8:0] Mod     = 9'(MOD_LO);
  localparam logic [7:0] LastStp = 8'(INV_SHIFT - 1);

  typedef enum logic [2:0] {StIdle, StSub, StDbl, StComb, StDone} state_e;

  state_e     state;
  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic [7:0] d;
  logic [7:0] step;
  logic [3:0] tag_hold;
  logic       err;

  logic [8:0] hi_mod;
  logic [7:0] diff;
  logic [7:0] dbl;

  assign in_ready = (state == StIdle);

  // r_hi < 2*MOD_LO for MOD_LO > 127, so one subtract reduces it fully
  always_comb begin
    hi_mod = ({1'b0, r_hi} >= Mod) ? {1'b0, r_hi} - Mod : {1'b0, r_hi};
    diff   = ({1'b0, r_lo} >= hi_mod) ? 8'({1'b0, r_lo} - hi_mod)
                                      : 8'({1'b0, r_lo} + Mod - hi_mod);
    dbl    = ({d, 1'b0} >= Mod) ? 8'({d, 1'b0} - Mod) : 8'({d, 1'b0});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      r_hi      <= '0;
      r_lo      <= '0;
      d         <= '0;
      step      <= '0;
      tag_hold  <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      tag_out   <= '0;
      out_err   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            r_hi     <= din[15:8];
            r_lo     <= din[7:0];
            tag_hold <= tag_in;
            err      <= ({1'b0, din[7:0]} >= Mod);
            state    <= StSub;
          end
        end
        StSub: begin
          // an out-of-range r_lo is zeroed so it cannot leak into d
          d     <= err ? 8'd0 : diff;
          step  <= '0;
          state <= StDbl;
        end
        StDbl: begin
          d    <= dbl;
          step <= step + 8'd1;
          if (step == LastStp) state <= StComb;
        end
        StComb: begin
          dout      <= err ? 16'd0 : {d, r_hi};
          tag_out   <= tag_hold;
          out_err   <= err;
          out_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_reconstruct.sv
// Directed-vector bench for rns_reconstruct with hand-computed results.
module tb_rns_reconstruct;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic [3:0]  tag_out;
  logic        out_err;

  int n_vec = 0;
  int n_err = 0;

  rns_reconstruct #(.MOD_LO(129), .INV_SHIFT(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .tag_out   (tag_out),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers a pair now, waits for the result, optionally stalls the consumer
  // for hold cycles while poking in_valid, then releases it.
  task automatic apply(input logic [15:0] d, input logic [3:0] t, input logic [15:0] exp_d,
                       input logic exp_e, input int hold);
    int edges;
    check("in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    din      = d;
    tag_in   = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = 16'(~d);
    tag_in   = ~t;
    edges    = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", 32'(edges), 32'd8);
    check("dout", 32'(dout), 32'(exp_d));
    check("tag_out", 32'(tag_out), 32'(t));
    check("out_err", 32'(out_err), 32'(exp_e));
    if (hold > 0) in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      din = 16'(i * 16'h1111);
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_dout", 32'(dout), 32'(exp_d));
      check("hold_tag", 32'(tag_out), 32'(t));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("released_valid", 32'(out_valid), 32'd0);
    check("released_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = 16'h0;
    tag_in    = 4'h0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_tag", 32'(tag_out), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);

    // release at a negedge so the next rising edge is the first possible transfer
    @(negedge clk);
    reset = 1'b1;
    apply(16'h0505, 4'h3, 16'd5, 1'b0, 0);
    apply(16'hE861, 4'h5, 16'h03E8, 1'b0, 0);
    apply(16'hFF80, 4'hA, 16'h80FF, 1'b0, 0);
    apply(16'h8100, 4'h6, 16'h0081, 1'b0, 0);
    apply(16'hFE7F, 4'hC, 16'h80FE, 1'b0, 0);
    apply(16'h1281, 4'hF, 16'h0000, 1'b1, 0);
    apply(16'hE861, 4'h9, 16'h03E8, 1'b0, 5);

    // abort a conversion mid-doubling
    in_valid = 1'b1;
    din      = 16'h3C40;
    tag_in   = 4'h7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_tag", 32'(tag_out), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    seen  = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_valid_after_abort", 32'(seen), 32'd0);
    @(negedge clk);
    apply(16'h0505, 4'h3, 16'd5, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
